// File: rtl/proc_pkg.sv
// ============================================================================
// Module   : proc_pkg
// Brief    : Shared opcodes, instruction field positions and fetch FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int TGT_MSB = 3;
    localparam int TGT_LSB = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_ISSUE  = 3'd3;
    localparam state_t ST_HALT   = 3'd4;
    localparam state_t ST_PAUSE  = 3'd5;

    function automatic logic [3:0] get_opcode(input logic [15:0] inst);
        return inst[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [3:0] get_target(input logic [15:0] inst);
        return inst[TGT_MSB:TGT_LSB];
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_pc_unit.sv
// ============================================================================
// Module   : pc_unit
// Brief    : 4-bit program counter with load and wrapping increment.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_unit #(
    parameter logic [3:0] RESET_PC = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       inc,
    output logic [3:0] pc
);

    logic [3:0] pc_q;
    logic [3:0] pc_d;

    // Load wins over increment; the FSM never requests both at once.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Instruction fetch FSM; resolves HALT/JMP, issues the rest over
//            valid/ready. Optional single-step via FETCH_SEQ_SINGLE_STEP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
    import proc_pkg::*;
#(
    parameter logic [3:0] RESET_PC = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef FETCH_SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic [3:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [15:0] issue_inst,
    output logic [3:0]  pc,
    output logic        busy,
    output logic        halted
);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] ir_q;
    logic [3:0]  w_opcode;
    logic        w_pc_load;
    logic [3:0]  w_pc_load_val;
    logic        w_pc_inc;
    logic        w_ir_load;

    assign w_opcode = get_opcode(ir_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_opcode == OP_HALT) begin
                    state_d = ST_HALT;
                end else if (w_opcode == OP_JMP) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
`ifdef FETCH_SEQ_SINGLE_STEP_EN
                    state_d = ST_PAUSE;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
`ifdef FETCH_SEQ_SINGLE_STEP_EN
            ST_PAUSE: begin
                if (step) state_d = ST_FETCH;
            end
`endif
            ST_HALT: begin
                if (start) state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All outputs decode registered state only, so issue_ready never
    // reaches issue_valid combinationally.
    always_comb begin
        w_pc_load     = 1'b0;
        w_pc_load_val = RESET_PC;
        w_pc_inc      = 1'b0;
        w_ir_load     = 1'b0;
        issue_valid   = 1'b0;
        busy          = 1'b1;
        halted        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy      = 1'b0;
                w_pc_load = start;
            end
            ST_FETCH: begin
                w_ir_load = 1'b1;
            end
            ST_DECODE: begin
                if (w_opcode == OP_JMP) begin
                    w_pc_load     = 1'b1;
                    w_pc_load_val = get_target(ir_q);
                end
            end
            ST_ISSUE: begin
                issue_valid = 1'b1;
                w_pc_inc    = issue_ready;
            end
            ST_HALT: begin
                busy      = 1'b0;
                halted    = 1'b1;
                w_pc_load = start;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q <= 16'h0000;
        end else if (w_ir_load) begin
            ir_q <= rom_data;
        end
    end

    pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk      (clk),
        .rst      (rst),
        .load     (w_pc_load),
        .load_val (w_pc_load_val),
        .inc      (w_pc_inc),
        .pc       (pc)
    );

    assign rom_addr   = pc;
    assign issue_inst = ir_q;

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the 16-bit, 16-entry program ROM. Owns the 4-bit program counter, drives the ROM address, latches the returned instruction, resolves halt and jump locally, and hands all other instructions to the execute datapath over a valid/ready handshake. Sits between the program ROM and the register file/ALU datapath.

## Interface
- Parameters:
- `RESET_PC`, 4'd0, PC loaded on reset and on `start`.
- Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; starts execution from `RESET_PC`. Honoured only in IDLE or HALT.
- `rom_addr`  out  4  address to the program ROM; equals `pc`.
- `rom_data`  in  16  instruction from the ROM; combinational, valid in the same cycle.
- `issue_valid`  out  1  `issue_inst` holds an instruction for the datapath.
- `issue_ready`  in  1  datapath accepts this cycle.
- `issue_inst`  out  16  latched instruction register (IR).
- `pc`  out  4  current program counter.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.

## Operation
- Opcode is `inst[15:12]`. `4'b0000` = HALT and `4'b1110` = JMP (target = `inst[3:0]`) are consumed by the sequencer and never issued. All other opcodes (addi `0001`, add `0010`, out `1111`, …) are issued unmodified.
- States: IDLE, FETCH, DECODE, ISSUE, HALT (+ PAUSE, see Configuration).
- IDLE: wait for `start` -> `pc<=RESET_PC`, go to FETCH.
- FETCH: `rom_addr=pc`; IR <= `rom_data` at the clock edge -> DECODE.
- DECODE: HALT opcode -> HALT, PC unchanged. JMP -> `pc<=inst[3:0]`, FETCH. Otherwise -> ISSUE.
- ISSUE: `issue_valid=1`, `issue_inst=IR` held stable. On `issue_valid&&issue_ready`: `pc<=pc+1` (mod 16; 15 wraps to 0) -> FETCH.
- HALT: `halted=1`; `start` restarts the program as it does from IDLE.
- `start` in FETCH, DECODE or ISSUE is ignored.
- JMP to its own address is a legal infinite loop; no detection.

## Timing
- Reset values: state IDLE, `pc=RESET_PC`, IR=16'h0000, `issue_valid=0`, `busy=0`, `halted=0`.
- `rst` asserted in any state, including mid-handshake, aborts immediately. `issue_valid` drops asynchronously and no partial issue counts.
- Issued instruction: `start` at cycle 0, FETCH at cycle 1, DECODE at cycle 2, `issue_valid` at cycle 3. With `issue_ready` held high, one instruction issues every 3 cycles.
- JMP costs 2 cycles (FETCH, DECODE). HALT is reached 2 cycles after its FETCH.
- `issue_valid` never deasserts without a handshake. `issue_inst` never changes while `issue_valid` is high.
- `issue_ready` is ignored outside ISSUE.
- All outputs are registered-state decodes. There is no combinational path from `issue_ready` to `issue_valid`.

## Configuration
- `FETCH_SEQ_SINGLE_STEP_EN` defined:
  - Adds input port `step` (1 bit).
  - After each ISSUE handshake the FSM enters PAUSE instead of FETCH, with the PC already incremented.
  - PAUSE -> FETCH on a `step` pulse. `busy=1` in PAUSE.
  - JMP and HALT do not pause.
- Undefined: no `step` port and no PAUSE state. ISSUE goes straight to FETCH.

## Structure
- Shared package `proc_pkg`:
  - opcode constants `OP_HALT`, `OP_ADDI`, `OP_ADD`, `OP_JMP`, `OP_OUT`
  - field positions: opcode `[15:12]`, jump target `[3:0]`
  - FSM state encoding
- Natural sub-module: `pc_unit`, the PC register with load (`RESET_PC` or jump target) and increment-mod-16. The FSM in `fetch_sequencer` drives its controls.

## Test plan
- Reset: hold `rst` with random inputs -> `pc=0`, `issue_valid=0`, `busy=0`, `halted=0`, state IDLE.
- ROM program addi r1 3 / addi r2 7 / add r1 r2, `issue_ready=1`, `start` at cycle 0:
  - `issue_inst` = 16'h1203 at cycle 3, 16'h1407 at cycle 6, 16'h228F at cycle 9
  - `pc` = 1, 2, 3 after the respective handshakes
- Backpressure: `issue_ready=0` for 5 cycles during ISSUE -> `issue_valid` and `issue_inst` stable for those cycles; PC advances only on the ready cycle.
- JMP 16'hE005 at addr 2 -> nothing issued for it; the next FETCH has `rom_addr=5`. PC 15 with a non-control opcode -> after the handshake `pc=0`.
- HALT 16'h0000 at addr 4 -> `halted=1` and `busy=0` 2 cycles after its FETCH; a later `start` -> fetch resumes at addr 0.
- `rst` pulse during ISSUE with `issue_ready=0` -> `issue_valid` low immediately, no handshake counted, PC=0. With the macro defined: no FETCH until a `step` pulse after each issue.
